// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundle of the four-requester / one-consumer bus around mux4_rr_arbiter.
//
// Signals:
//   req      [3:0]  request per source (bit0=A .. bit3=D)
//   A,B,C,D  [W-1:0] per-source data, stable while req is high until ack
//   ack      [3:0]  one-hot, one-cycle capture pulse back to the source
//   sel      [1:0]  index of the granted source (mux select)
//   y        [W-1:0] registered selected word
//   y_valid         y holds a word not yet accepted
//   y_ready         consumer accepts y on an edge with y_valid=1
//   busy            mirror of y_valid
//
// Handshake: a word moves downstream on every rising clk edge where
// y_valid=1 and y_ready=1; while y_valid=1 and y_ready=0 the arbiter keeps
// y and sel frozen, and y_ready is ignored while y_valid=0.
//
// Modports:
//   master : the arbiter side (drives ack/sel/y/y_valid/busy)
//   slave  : the producers + consumer side (drives req/data/y_ready)
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             busy;

  modport master (
    input  req, A, B, C, D, y_ready,
    output ack, sel, y, y_valid, busy
  );

  modport slave (
    output req, A, B, C, D, y_ready,
    input  ack, sel, y, y_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter in front of a 4:1 mux. Picks one pending source,
// registers its word into y and offers it downstream on a valid/ready
// handshake. One word per cycle when the consumer keeps y_ready high.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          mux4_rr_arbiter_if.master (req, A-D, ack, sel, y,
//                y_valid, y_ready, busy)
//   o_dbg_state  current FSM state (0=IDLE, 1=SEND)
//   o_dbg_ptr    last-grant pointer used by the priority search
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4_rr_arbiter_if.master   bus,
  output logic                o_dbg_state,
  output logic [1:0]          o_dbg_ptr
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic [3:0]       r_ack;

  logic [3:0]       w_elig;
  logic [1:0]       w_base;
  logic [1:0]       w_idx;
  logic [1:0]       w_win;
  logic             w_found;
  logic [WIDTH-1:0] w_data;

  // A source whose ack is on the wire this cycle may still hold req high
  // while it reacts; masking it avoids granting the same word twice.
  assign w_elig = bus.req & ~r_ack;

  // On an accept edge the pointer becomes sel in the same edge, so the
  // search must already start from sel. In IDLE the stored pointer is used
  // (it only differs from sel right after reset).
  assign w_base = (r_state == ST_SEND) ? r_sel : r_ptr;

  // Search base+1 .. base+4 (mod 4); the first eligible source wins.
  always_comb begin
    w_win   = w_base;
    w_found = 1'b0;
    w_idx   = w_base;
    for (int i = 1; i <= 4; i++) begin
      w_idx = w_base + 2'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = bus.A;
    case (w_win)
      2'd0:    w_data = bus.A;
      2'd1:    w_data = bus.B;
      2'd2:    w_data = bus.C;
      default: w_data = bus.D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd3;
      r_sel   <= 2'd0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_ack   <= 4'b0000;
    end else begin
      r_ack <= 4'b0000;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_y     <= w_data;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_ack   <= 4'b0001 << w_win;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.y_ready) begin
            r_ptr <= r_sel;
            if (w_found) begin
              r_y     <= w_data;
              r_sel   <= w_win;
              r_ack   <= 4'b0001 << w_win;
            end else begin
              // y and sel keep their last values while idle.
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.sel     = r_sel;
  assign bus.y       = r_y;
  assign bus.y_valid = r_valid;
  assign bus.busy    = r_valid;

  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter: a table of directed vectors,
// hand-written sequences for backpressure and reset-in-SEND, then random
// traffic compared every cycle against a behavioural model plus a
// scoreboard of words the consumer should receive in order.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.WIDTH(W)) bus ();
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state in plain integers: who holds y, which source was last
  // served, and which source is being acknowledged this cycle.
  int           m_ptr;
  int           m_sel;
  logic         m_valid;
  logic [W-1:0] m_y;
  logic [3:0]   m_ack;

  function automatic int pick(input int p, input logic [3:0] e);
    for (int k = 1; k <= 4; k++) begin
      if (e[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_update();
    logic [W-1:0] data [4];
    logic [3:0]   elig;
    int           w;
    data[0] = bus.A; data[1] = bus.B; data[2] = bus.C; data[3] = bus.D;
    if (!rst_n) begin
      m_ptr = 3; m_sel = 0; m_valid = 1'b0; m_y = '0; m_ack = 4'b0000;
    end else begin
      elig  = bus.req & ~m_ack;
      m_ack = 4'b0000;
      w     = -1;
      if (!m_valid) begin
        w = pick(m_ptr, elig);
      end else if (bus.y_ready) begin
        m_ptr = m_sel;
        w = pick(m_ptr, elig);
        if (w < 0) m_valid = 1'b0;
      end
      if (w >= 0) begin
        m_y     = data[w];
        m_sel   = w;
        m_valid = 1'b1;
        m_ack   = 4'b0001 << w;
        exp_q.push_back(data[w]);
      end
    end
  endtask

  // ---------------- one clock step: edge, scoreboard, model, compare ----
  task automatic step();
    logic         prev_valid;
    logic [W-1:0] prev_y;
    logic [W-1:0] exp_w;
    prev_valid = bus.y_valid;
    prev_y     = bus.y;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else if (prev_valid === 1'b1 && bus.y_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_accept", 32'(prev_y), 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        chk("sb_accepted_word", 32'(prev_y), 32'(exp_w));
      end
    end
    model_update();
    chk("y",       32'(bus.y),       32'(m_y));
    chk("sel",     32'(bus.sel),     32'(m_sel));
    chk("y_valid", 32'(bus.y_valid), 32'(m_valid));
    chk("busy",    32'(bus.busy),    32'(m_valid));
    chk("ack",     32'(bus.ack),     32'(m_ack));
    chk("ack_onehot0", 32'($countones(bus.ack) <= 1), 32'd1);
    chk("state",   32'(dbg_state),   32'(m_valid));
    chk("ptr",     32'(dbg_ptr),     32'(m_ptr));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [3:0] r, input logic rdy);
    rst_n       = rst;
    bus.req     = r;
    bus.y_ready = rdy;
  endtask

  task automatic set_data(input logic [W-1:0] a, b, c, d);
    bus.A = a; bus.B = b; bus.C = c; bus.D = d;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic         rdy;
    logic [1:0]   e_sel;
    logic [W-1:0] e_y;
    logic         e_valid;
    logic [3:0]   e_ack;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic rdy,
                              input logic [1:0] s, input logic [W-1:0] y,
                              input logic v, input logic [3:0] a);
    vec_t t;
    t.rst = rst; t.req = req; t.rdy = rdy;
    t.e_sel = s; t.e_y = y; t.e_valid = v; t.e_ack = a;
    return t;
  endfunction

  int pulses;

  initial begin
    // Reset with every source requesting, then round-robin through all four,
    // then a lone request on C and the pointer-relative ordering after it.
    tbl[0]  = mk(1'b0, 4'b1111, 1'b1, 2'd0, 8'h00, 1'b0, 4'b0000);
    tbl[1]  = mk(1'b0, 4'b1111, 1'b1, 2'd0, 8'h00, 1'b0, 4'b0000);
    tbl[2]  = mk(1'b1, 4'b1111, 1'b1, 2'd0, 8'h11, 1'b1, 4'b0001);
    tbl[3]  = mk(1'b1, 4'b1111, 1'b1, 2'd1, 8'h22, 1'b1, 4'b0010);
    tbl[4]  = mk(1'b1, 4'b1111, 1'b1, 2'd2, 8'h33, 1'b1, 4'b0100);
    tbl[5]  = mk(1'b1, 4'b1111, 1'b1, 2'd3, 8'h44, 1'b1, 4'b1000);
    tbl[6]  = mk(1'b1, 4'b1111, 1'b1, 2'd0, 8'h11, 1'b1, 4'b0001);
    tbl[7]  = mk(1'b1, 4'b0000, 1'b1, 2'd0, 8'h11, 1'b0, 4'b0000);
    tbl[8]  = mk(1'b1, 4'b0100, 1'b0, 2'd2, 8'h33, 1'b1, 4'b0100);
    tbl[9]  = mk(1'b1, 4'b1010, 1'b1, 2'd3, 8'h44, 1'b1, 4'b1000);
    tbl[10] = mk(1'b1, 4'b1010, 1'b1, 2'd1, 8'h22, 1'b1, 4'b0010);
    tbl[11] = mk(1'b1, 4'b0000, 1'b1, 2'd1, 8'h22, 1'b0, 4'b0000);
    tbl[12] = mk(1'b1, 4'b0000, 1'b1, 2'd1, 8'h22, 1'b0, 4'b0000);

    m_ptr = 3; m_sel = 0; m_valid = 1'b0; m_y = '0; m_ack = 4'b0000;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    drive(1'b0, 4'b1111, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_sel", i),   32'(bus.sel),     32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_y", i),     32'(bus.y),       32'(tbl[i].e_y));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.y_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ack", i),   32'(bus.ack),     32'(tbl[i].e_ack));
    end

    // Backpressure: B granted, then B's data changes while held.
    set_data(8'h11, 8'hAA, 8'h33, 8'h44);
    drive(1'b1, 4'b0010, 1'b0);
    step();
    pulses = (bus.ack[1] === 1'b1) ? 1 : 0;
    chk("bp_grant_sel", 32'(bus.sel), 32'd1);
    chk("bp_grant_y",   32'(bus.y),   32'hAA);
    bus.B   = 8'h55;
    bus.req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.ack[1] === 1'b1) pulses++;
      chk("bp_hold_y",     32'(bus.y),       32'hAA);
      chk("bp_hold_valid", 32'(bus.y_valid), 32'd1);
      chk("bp_hold_sel",   32'(bus.sel),     32'd1);
    end
    chk("bp_ack_pulses", 32'(pulses), 32'd1);
    drive(1'b1, 4'b0000, 1'b1);
    step();
    chk("bp_drain_valid", 32'(bus.y_valid), 32'd0);

    // Reset while a word is held; source 0 must win first afterwards.
    drive(1'b1, 4'b1111, 1'b0);
    step();
    chk("rs_held_valid", 32'(bus.y_valid), 32'd1);
    drive(1'b0, 4'b1111, 1'b0);
    step();
    chk("rs_valid", 32'(bus.y_valid), 32'd0);
    chk("rs_y",     32'(bus.y),       32'd0);
    chk("rs_sel",   32'(bus.sel),     32'd0);
    drive(1'b1, 4'b1111, 1'b0);
    step();
    chk("rs_first_sel", 32'(bus.sel), 32'd0);
    chk("rs_first_y",   32'(bus.y),   32'(bus.A));
    drive(1'b1, 4'b0000, 1'b1);
    step();

    // Idle with the consumer ready and nothing requested.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0000, 1'b1);
      step();
      chk("idle_valid", 32'(bus.y_valid), 32'd0);
      chk("idle_ack",   32'(bus.ack),     32'd0);
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      set_data(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      drive(($urandom_range(0, 59) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
